// File: rtl/display_scan_driver_if.sv
// Clock/reset record type and the LED driver chain interface used by the
// front-panel scan driver.
package ckrs_pkg;
   typedef struct packed {
      logic clk;
      logic reset;
   } ckrs_t;
endpackage

interface t_display;
   logic       latch;
   logic       blank;
   logic [2:0] csel;
   logic       sclk;
   logic       sin;

   modport producer (output latch, blank, csel, sclk, sin);
   modport consumer (input  latch, blank, csel, sclk, sin);
endinterface

// File: rtl/display_scan_driver.sv
// Serialises an 8-column LED frame into chained shift-register drivers, latches
// each column and multiplexes csel, blanking the panel while columns switch.
module display_scan_driver
   import ckrs_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int BITS    = 32,
   parameter int COLUMNS = 8
) (
   input  ckrs_t                     ClkRs_ix,
   input  logic                      enable_ix,
   input  logic [COLUMNS*BITS-1:0]   frame_ix,
   output logic                      frame_done_ox,
   t_display.producer                display_x
);

   localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
   localparam logic [PRE_W-1:0] LAST_DIV = PRE_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);
   localparam logic [2:0]       LAST_COL = 3'(COLUMNS - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SH_LO,
      SH_HI,
      BLANK,
      LATCH
   } state_t;

   logic clk;
   logic rst_n;

   assign clk   = ClkRs_ix.clk;
   assign rst_n = ClkRs_ix.reset;

   state_t                    state_q,     state_d;
   logic [PRE_W-1:0]          presc_q,     presc_d;
   logic [2:0]                shift_col_q, shift_col_d;
   logic [CNT_W-1:0]          bit_cnt_q,   bit_cnt_d;
   logic [BITS-1:0]           shift_q,     shift_d;
   logic [COLUMNS*BITS-1:0]   frame_q,     frame_d;
   logic                      latch_q,     latch_d;
   logic                      blank_q,     blank_d;
   logic [2:0]                csel_q,      csel_d;
   logic                      sclk_q,      sclk_d;
   logic                      sin_q,       sin_d;
   logic                      done_q,      done_d;

   logic                      tick;
   logic [CNT_W-1:0]          next_bit;
   logic [BITS-1:0]           load_word;
   logic [BITS-1:0]           frame_cols [COLUMNS];

   assign tick     = (presc_q == LAST_DIV);
   assign next_bit = bit_cnt_q - CNT_W'(1);

   // Column 0 comes straight from the live input because that is the cycle
   // the snapshot is taken; later columns read the frozen copy so frames never tear.
   always_comb begin
      for (int c = 0; c < COLUMNS; c++) begin
         frame_cols[c] = frame_q[c*BITS +: BITS];
      end
      if (shift_col_q == 3'd0) begin
         load_word = frame_ix[BITS-1:0];
      end else begin
         load_word = frame_cols[shift_col_q];
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_col_d = shift_col_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      frame_d     = frame_q;
      blank_d     = blank_q;
      csel_d      = csel_q;
      sin_d       = sin_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            blank_d = 1'b1;
            if (enable_ix) begin
               state_d     = LOAD;
               shift_col_d = 3'd0;
            end
         end
         LOAD: begin
            if (shift_col_q == 3'd0) begin
               frame_d = frame_ix;
            end
            shift_d   = load_word;
            bit_cnt_d = LAST_BIT;
            sin_d     = load_word[BITS-1];
            state_d   = SH_LO;
         end
         SH_LO: begin
            if (tick) begin
               state_d = SH_HI;
            end
         end
         SH_HI: begin
            if (tick) begin
               if (bit_cnt_q == '0) begin
                  state_d = BLANK;
                  blank_d = 1'b1;
               end else begin
                  bit_cnt_d = next_bit;
                  sin_d     = shift_q[next_bit];
                  state_d   = SH_LO;
               end
            end
         end
         BLANK: begin
            if (tick) begin
               state_d = LATCH;
               csel_d  = shift_col_q;
               done_d  = (shift_col_q == LAST_COL);
            end
         end
         LATCH: begin
            if (tick) begin
               shift_col_d = (shift_col_q == LAST_COL) ? 3'd0 : shift_col_q + 3'd1;
               if (enable_ix) begin
                  state_d = LOAD;
                  blank_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            blank_d = 1'b1;
         end
      endcase

      latch_d = (state_d == LATCH);
      sclk_d  = (state_d == SH_HI);

      // Prescaler is parked at zero in IDLE and LOAD so every timed phase
      // starts on a fresh count and lasts exactly CLK_DIV clocks.
      if (state_q == IDLE || state_q == LOAD || tick) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + PRE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         presc_q     <= '0;
         shift_col_q <= 3'd0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         frame_q     <= '0;
         latch_q     <= 1'b0;
         blank_q     <= 1'b1;
         csel_q      <= 3'd0;
         sclk_q      <= 1'b0;
         sin_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         shift_col_q <= shift_col_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         frame_q     <= frame_d;
         latch_q     <= latch_d;
         blank_q     <= blank_d;
         csel_q      <= csel_d;
         sclk_q      <= sclk_d;
         sin_q       <= sin_d;
         done_q      <= done_d;
      end
   end

   assign display_x.latch = latch_q;
   assign display_x.blank = blank_q;
   assign display_x.csel  = csel_q;
   assign display_x.sclk  = sclk_q;
   assign display_x.sin   = sin_q;
   assign frame_done_ox   = done_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomised bench for display_scan_driver: expected columns are queued as the
// frame image is applied and a monitor pops them at every latch pulse.
module tb_display_scan_driver;
   import ckrs_pkg::*;

   localparam int CLK_DIV    = 4;
   localparam int BITS       = 32;
   localparam int COLUMNS    = 8;
   localparam int COL_CLKS   = (2*BITS + 2)*CLK_DIV + 1;
   localparam int FRAME_CLKS = COL_CLKS*COLUMNS;

   typedef logic [COLUMNS*BITS-1:0] frame_t;
   typedef struct {
      int              col;
      logic [BITS-1:0] data;
   } exp_t;

   logic   clk    = 1'b0;
   logic   rst_n  = 1'b0;
   logic   enable = 1'b0;
   frame_t frame  = '0;
   logic   frame_done;
   ckrs_t  clk_rs;

   assign clk_rs = '{clk: clk, reset: rst_n};

   t_display disp();

   display_scan_driver #(
      .CLK_DIV (CLK_DIV),
      .BITS    (BITS),
      .COLUMNS (COLUMNS)
   ) dut (
      .ClkRs_ix      (clk_rs),
      .enable_ix     (enable),
      .frame_ix      (frame),
      .frame_done_ox (frame_done),
      .display_x     (disp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic pushColumns(input frame_t img, input int ncols);
      for (int c = 0; c < ncols; c++) begin
         exp_t e;
         e.col  = c;
         e.data = img[c*BITS +: BITS];
         exp_q.push_back(e);
      end
   endtask

   task automatic applyStimulus(input logic en, input frame_t img);
      @(negedge clk);
      enable = en;
      frame  = img;
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   function automatic frame_t randomFrame();
      frame_t f;
      for (int c = 0; c < COLUMNS; c++) f[c*BITS +: BITS] = BITS'($urandom);
      return f;
   endfunction

   // Monitor: rebuilds each column from sin at sclk rises and scores it at latch.
   logic            prev_sclk      = 1'b0;
   logic            prev_latch     = 1'b0;
   logic [2:0]      prev_csel      = 3'd0;
   logic [BITS-1:0] shift_word     = '0;
   int              nbits          = 0;
   int              prev_latch_cyc = 0;
   logic            have_prev      = 1'b0;
   logic            run_broken     = 1'b1;
   logic            latch_bad      = 1'b0;
   int              done_seen      = 0;
   int              done_expected  = 0;
   exp_t            mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         nbits      = 0;
         shift_word = '0;
         run_broken = 1'b1;
         prev_sclk  = disp.sclk;
         prev_latch = disp.latch;
         prev_csel  = disp.csel;
      end else begin
         if (!enable) run_broken = 1'b1;
         if (frame_done) done_seen++;
         if (disp.sclk && !prev_sclk) begin
            shift_word = {shift_word[BITS-2:0], disp.sin};
            nbits++;
         end
         if (disp.csel != prev_csel) checkOutput("csel_change_blank", 64'(disp.blank), 64'd1);
         if (disp.latch && !prev_latch) begin
            checkOutput("latch_blank", 64'(disp.blank), 64'd1);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_latch: got csel=%0d, expected no latch (cycle %0d)", disp.csel, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("csel", 64'(disp.csel), 64'(mon_e.col));
               checkOutput("col_data", 64'(shift_word), 64'(mon_e.data));
               checkOutput("bit_count", 64'(nbits), 64'(BITS));
               checkOutput("frame_done", 64'(frame_done), 64'(mon_e.col == COLUMNS-1));
               if (mon_e.col == COLUMNS-1) done_expected++;
            end
            if (have_prev && !run_broken)
               checkOutput("column_period", 64'(cyc - prev_latch_cyc), 64'(COL_CLKS));
            have_prev      = 1'b1;
            run_broken     = 1'b0;
            prev_latch_cyc = cyc;
            latch_bad      = 1'b0;
            nbits          = 0;
            shift_word     = '0;
         end
         if (disp.latch && !disp.blank) latch_bad = 1'b1;
         if (!disp.latch && prev_latch) begin
            checkOutput("latch_width", 64'(cyc - prev_latch_cyc), 64'(CLK_DIV));
            checkOutput("latch_blank_hold", 64'(latch_bad), 64'd0);
            checkOutput("blank_after_latch", 64'(disp.blank), 64'(!enable));
         end
         prev_sclk  = disp.sclk;
         prev_latch = disp.latch;
         prev_csel  = disp.csel;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      frame_t img0, img1, img2, img3, img4;
      int     start;
      int     n;
      int     noisy;

      // Reset with scanning disabled
      frame = randomFrame();
      repeat (3) @(negedge clk);
      checkOutput("rst_latch", 64'(disp.latch), 64'd0);
      checkOutput("rst_blank", 64'(disp.blank), 64'd1);
      checkOutput("rst_csel",  64'(disp.csel),  64'd0);
      checkOutput("rst_sclk",  64'(disp.sclk),  64'd0);
      checkOutput("rst_sin",   64'(disp.sin),   64'd0);
      checkOutput("rst_done",  64'(frame_done), 64'd0);
      rst_n = 1'b1;
      noisy = 0;
      repeat (100) begin
         @(negedge clk);
         if (disp.latch !== 1'b0 || disp.blank !== 1'b1 || disp.csel !== 3'd0 ||
             disp.sclk !== 1'b0 || disp.sin !== 1'b0 || frame_done !== 1'b0) noisy++;
      end
      checkOutput("idle_quiet", 64'(noisy), 64'd0);

      // First frame: column 0 fixed pattern, first sclk rise 5 clocks after LOAD
      img0 = randomFrame();
      img0[BITS-1:0] = 32'hA5A5_0001;
      pushColumns(img0, COLUMNS);
      applyStimulus(1'b1, img0);
      @(negedge clk);
      start = cyc;
      n = 1;
      while (!disp.sclk && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("first_sclk_delay", 64'(n - 1), 64'd5);
      checkOutput("blank_initial", 64'(disp.blank), 64'd1);

      // New striped image arrives mid column 3; it must wait for the next frame
      for (int c = 0; c < COLUMNS; c++) img1[c*BITS +: BITS] = BITS'(32'h1111_1111 * c);
      waitUntil(start + 3*COL_CLKS + 60 + int'($urandom_range(0, 150)));
      frame = img1;
      pushColumns(img1, COLUMNS);
      pushColumns(img1, 6);

      // Drop enable while column 5 of the third frame shifts
      waitUntil(start + 2*FRAME_CLKS + 5*COL_CLKS + 20 + int'($urandom_range(0, 200)));
      enable = 1'b0;
      waitUntil(start + 2*FRAME_CLKS + 6*COL_CLKS + 20);
      checkOutput("stop_csel",  64'(disp.csel),  64'd5);
      checkOutput("stop_blank", 64'(disp.blank), 64'd1);
      checkOutput("stop_latch", 64'(disp.latch), 64'd0);
      checkOutput("stop_queue", 64'(exp_q.size()), 64'd0);
      repeat (50) @(negedge clk);
      checkOutput("idle_csel_hold",  64'(disp.csel),  64'd5);
      checkOutput("idle_blank_hold", 64'(disp.blank), 64'd1);

      // Re-enable restarts at column 0 with a fresh snapshot
      img2 = randomFrame();
      pushColumns(img2, COLUMNS);
      pushColumns(img2, 1);
      applyStimulus(1'b1, img2);
      @(negedge clk);
      start = cyc;
      waitUntil(start + FRAME_CLKS + 30 + int'($urandom_range(0, 150)));
      enable = 1'b0;
      waitUntil(start + FRAME_CLKS + COL_CLKS + 20);
      checkOutput("reenable_queue", 64'(exp_q.size()), 64'd0);

      // Reset asserted in the middle of an sclk-high phase of column 2
      img3 = randomFrame();
      pushColumns(img3, 2);
      applyStimulus(1'b1, img3);
      @(negedge clk);
      start = cyc;
      waitUntil(start + 2*COL_CLKS + 40 + int'($urandom_range(0, 100)));
      n = 0;
      while (!disp.sclk && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reached_sh_hi", 64'(disp.sclk), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_sclk",  64'(disp.sclk),  64'd0);
      checkOutput("async_blank", 64'(disp.blank), 64'd1);
      checkOutput("async_latch", 64'(disp.latch), 64'd0);
      checkOutput("async_csel",  64'(disp.csel),  64'd0);
      checkOutput("async_done",  64'(frame_done), 64'd0);
      checkOutput("reset_queue", 64'(exp_q.size()), 64'd0);
      img4 = randomFrame();
      frame = img4;
      repeat (3) @(negedge clk);
      pushColumns(img4, COLUMNS);
      pushColumns(img4, 1);
      rst_n = 1'b1;
      @(negedge clk);
      start = cyc;
      waitUntil(start + FRAME_CLKS + 30 + int'($urandom_range(0, 150)));
      enable = 1'b0;
      waitUntil(start + FRAME_CLKS + COL_CLKS + 20);
      repeat (20) @(negedge clk);

      checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
      checkOutput("frame_done_count", 64'(done_seen), 64'(done_expected));
      checkOutput("frames_completed", 64'(done_expected), 64'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Drives the front-panel LED driver chain through the t_display producer modport.
- Serialises an 8-column LED frame image into the shift-register drivers and pulses latch.
- Multiplexes the column select csel, and uses blank to suppress ghosting while columns switch.
- Sits between the status/diagnostic logic that builds the LED frame and the top-level display pins.

Parameters:
- CLK_DIV, 4: system clocks per sclk half-period; must be >= 1. The default gives 12.5 MHz sclk at 100 MHz.
- BITS, 32: driver bits per column (two chained 16-bit drivers); must be >= 1.
- COLUMNS, 8: number of columns; fixed by the 3-bit csel, must be <= 8.

Ports:
- ClkRs_ix  input  ckrs_t  clock/reset record. .clk is the single clock; .reset is asynchronous, active-low.
- enable_ix  input  1  run scanning when 1.
- frame_ix  input  COLUMNS*BITS  LED image. Column c, bit b = frame_ix[c*BITS+b].
- frame_done_ox  output  1  one-cycle pulse when the column COLUMNS-1 is latched.
- display_x  t_display.producer  —  latch, blank, csel[2:0], sclk, sin to the LED drivers.

Behaviour:
- Reset (async assert, release synchronous to clk): latch=0, blank=1, csel=0, sclk=0, sin=0, frame_done_ox=0, FSM=IDLE, shift_col=0, prescaler=0.
  - Assertion mid-operation forces these values immediately, with no partial latch.
- Prescaler: counts 0..CLK_DIV-1 and issues a tick on the wrap. It runs only outside IDLE and restarts at 0 on leaving IDLE.
- All outputs are registered; no combinational paths from inputs to outputs.
- FSM states:
  - IDLE: blank=1, latch=0, sclk=0. Leave on enable_ix=1 → LOAD, with shift_col=0.
  - LOAD (1 clk): if shift_col==0, snapshot frame_ix into an internal frame register. Load shift register = column shift_col. bit_cnt=BITS-1 → SH_LO.
  - SH_LO (CLK_DIV clks): sclk=0; sin = shift bit bit_cnt, MSB first, set on state entry. On tick → SH_HI.
  - SH_HI (CLK_DIV clks): sclk=1; sin held. On tick: if bit_cnt==0 → BLANK, else decrement bit_cnt → SH_LO.
  - BLANK (CLK_DIV clks): sclk=0, blank=1. On tick → LATCH.
  - LATCH (CLK_DIV clks): latch=1, blank=1, csel<=shift_col on entry. frame_done_ox pulses on entry if shift_col==COLUMNS-1. On tick: latch=0; shift_col wraps COLUMNS-1→0. Then:
    - if enable_ix=1 → LOAD with blank=0;
    - else → IDLE with blank kept 1.
- Pipelining: column k is displayed (blank=0) while column k+1 is shifted.
- Initial start: column 0 is shifted while blank=1, so nothing shows until the first latch.
- Column period = (2*BITS+2)*CLK_DIV + 1 clks (LOAD adds 1) = 265 clks by default. Frame period = 2120 clks.
- enable_ix drop: sampled only at the end of LATCH. The current column always completes shift and latch; csel then holds the last value with blank=1.
- Re-enable from IDLE always restarts at column 0 with a fresh snapshot.
- Snapshot: frame_ix changes are visible only from the next column-0 LOAD, so frames never tear.
- latch and csel change only while blank=1. sin is stable for the full SH_HI phase, around the sclk rising edge.

Test Plan:
1. Reset (enable_ix=0): outputs are latch=0, blank=1, csel=0, sclk=0, sin=0, frame_done_ox=0. Hold 100 clks → no toggling.
2. CLK_DIV=4, column 0 = 0xA5A5_0001, enable_ix=1:
   - 32 sclk rises; sin at the rises = 1010_0101_1010_0101_0000_0000_0000_0001;
   - first rise 5 clks after LOAD;
   - latch high exactly 4 clks with blank=1; csel=0 at latch; blank falls at latch end.
3. Distinct pattern per column (column c = 32'h1111_1111*c), full frame:
   - csel sequence 0,1,…,7,0 at 265-clk spacing;
   - shifted data matches each column;
   - frame_done_ox pulses once per 2120 clks.
4. Snapshot coherence: change frame_ix while column 3 shifts → columns 3–7 still show the old image; the new image appears from the next column-0 latch.
5. Drop enable_ix mid-shift of column 5: shift and latch of column 5 complete, csel=5, then blank stays 1 in IDLE. Re-enable → column 0 is shifted and latched next.
6. Assert reset mid-SH_HI: same clock edge gives sclk=0, blank=1, latch=0, csel=0. After release with enable_ix=1, the scan restarts at column 0.
